imem_access_ctrl: RTL and testbench
===================================

Name: imem_access_ctrl

Overview:
- Owns the single port of the 1024-word instruction memory; the memory has a synchronous write and a 1-cycle registered read.
- After reset it runs a boot phase, in which a streaming program loader writes words sequentially.
- It then hands the port to the fetch stage and converts byte PCs into word indices, flagging bad fetches.
- A reload request drains fetch and re-enters the boot phase without a global reset.

Parameters:
- BASE_ADDR, 32'h0000_3000, byte address of instruction word 0 (text segment base).
- DEPTH_LOG2, 10, log2 of memory depth in words.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader instruction word.
- ld_last  in  1  marks final word of program.
- ld_ready  out  1  controller accepts loader word.
- reload_req  in  1  pulse: abandon RUN and reload program.
- if_req  in  1  fetch request.
- if_addr  in  32  fetch byte address (PC).
- if_gnt  out  1  fetch request accepted this cycle.
- if_valid  out  1  fetch result valid.
- if_ins  out  32  fetched instruction.
- if_err  out  1  fetch address misaligned or out of range; qualifies if_valid.
- mem_addr  out  DEPTH_LOG2  word index to memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid 1 cycle after mem_addr.
- cpu_run  out  1  high only in RUN; gates pipeline advance.
- load_count  out  DEPTH_LOG2+1  words accepted in the current load.
- ld_overflow  out  1  sticky: loader supplied more than 2^DEPTH_LOG2 words.

Behaviour:
- Reset (async) values:
  - state=LOAD; load_count=0; ld_overflow=0.
  - if_valid=0, if_err=0, if_ins=0.
  - cpu_run=0, if_gnt=0, mem_we=0, mem_addr=0.
  - ld_ready=1 from the first cycle after reset deasserts.
- States and transitions:
  - LOAD -> RUN: on the cycle after a handshake with ld_last=1.
  - RUN -> DRAIN: on reload_req.
  - DRAIN -> LOAD: unconditionally after 1 cycle.
- LOAD:
  - ld_ready=1; cpu_run=0; if_gnt=0; if_req is ignored.
  - Handshake (ld_valid&ld_ready): mem_we=1, mem_addr=load_count[DEPTH_LOG2-1:0], mem_wdata=ld_data, load_count++.
  - When load_count==2^DEPTH_LOG2: handshakes are still accepted but mem_we=0, ld_overflow is set, and load_count saturates.
  - ld_last with ld_valid=0 has no effect.
- RUN:
  - cpu_run=1; ld_ready=0; mem_we=0.
  - if_gnt=if_req, combinationally.
  - offset = if_addr - BASE_ADDR (32-bit unsigned); mem_addr = offset[DEPTH_LOG2+1:2].
  - Bad address: if_addr[1:0]!=0 or offset >= 4*2^DEPTH_LOG2. For a bad grant, the next cycle has if_valid=1, if_err=1 and if_ins=0 (the NOP encoding).
  - Good grant: the next cycle has if_valid=1, if_err=0 and if_ins=mem_rdata.
  - Back-to-back grants every cycle are allowed (throughput 1/cycle).
  - if_valid=0 in any cycle following a non-grant.
- DRAIN:
  - cpu_run=0; if_gnt=0.
  - The result of a grant made in the last RUN cycle is still delivered in DRAIN.
  - load_count clears to 0 on entry to LOAD; ld_overflow clears at the same time.
- Simultaneous events:
  - reload_req with if_req in the same RUN cycle: the request is granted, then the state moves to DRAIN.
  - reload_req outside RUN is ignored.
- if_ins/if_valid are registered outputs with no combinational path from if_req.

Test Plan:
- Reset, then stream 3 words 0x3C010001, 0x34210002, 0x00000000 with ld_last on the third -> mem_we pulses at indices 0,1,2 with matching data; load_count=3; cpu_run rises the cycle after the third handshake.
- RUN, if_req held with if_addr 0x3000, 0x3004, 0x3008 on consecutive cycles -> if_valid on 3 consecutive cycles, if_ins=0x3C010001, 0x34210002, 0x00000000, if_err=0.
- Fetch 0x3002 then 0x4000 -> two results with if_err=1 and if_ins=0; the third fetch 0x3000 returns 0x3C010001, if_err=0.
- Load 1025 words (DEPTH_LOG2=10) -> 1024 writes, 1025th accepted without mem_we, ld_overflow=1, load_count=1024.
- reload_req in the same cycle as a fetch of 0x3004 -> result delivered in DRAIN; next cycle LOAD with load_count=0, cpu_run=0 and ld_ready=1; a new 1-word load then returns to RUN.
- Assert reset mid-load after 5 words -> outputs immediately take reset values; after release, loading restarts at index 0.

Source files
------------

// File: rtl/imem_access_ctrl.sv
// Instruction memory port owner: boot-time program loader, then PC-to-word fetch path.
// A reload request drains the fetch path and restarts loading without a global reset.
module imem_access_ctrl #(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_3000,
   parameter int unsigned DEPTH_LOG2 = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  ld_valid,
   input  logic [31:0]           ld_data,
   input  logic                  ld_last,
   output logic                  ld_ready,
   input  logic                  reload_req,
   input  logic                  if_req,
   input  logic [31:0]           if_addr,
   output logic                  if_gnt,
   output logic                  if_valid,
   output logic [31:0]           if_ins,
   output logic                  if_err,
   output logic [DEPTH_LOG2-1:0] mem_addr,
   output logic                  mem_we,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   output logic                  cpu_run,
   output logic [DEPTH_LOG2:0]   load_count,
   output logic                  ld_overflow
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {StLoad, StRun, StDrain} state_e;

   state_e              state_q, state_d;
   logic [DEPTH_LOG2:0] count_q, count_d;
   logic                ovf_q, ovf_d;
   logic                valid_q, err_q;
   logic [31:0]         offset;
   logic                bad;
   logic                full;

   assign offset = if_addr - BASE_ADDR;
   assign bad    = (if_addr[1:0] != 2'b00) || (offset >= 32'(4 * Depth));
   // Count saturates at Depth, so the MSB alone marks a full memory.
   assign full   = count_q[DEPTH_LOG2];

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      ld_ready  = 1'b0;
      cpu_run   = 1'b0;
      if_gnt    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = ld_data;
      unique case (state_q)
         StLoad: begin
            ld_ready = !reset;
            mem_addr = count_q[DEPTH_LOG2-1:0];
            if (ld_valid && !reset) begin
               if (full) begin
                  ovf_d = 1'b1;
               end else begin
                  mem_we  = 1'b1;
                  count_d = count_q + 1'b1;
               end
               if (ld_last) state_d = StRun;
            end
         end
         StRun: begin
            cpu_run  = 1'b1;
            if_gnt   = if_req;
            mem_addr = offset[DEPTH_LOG2+1:2];
            if (reload_req) state_d = StDrain;
         end
         StDrain: begin
            state_d = StLoad;
            count_d = '0;
            ovf_d   = 1'b0;
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StLoad;
         count_q <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         valid_q <= if_gnt;
         err_q   <= if_gnt && bad;
      end
   end

   assign if_valid    = valid_q;
   assign if_err      = err_q;
   // Read data arrives one cycle after the address; bad fetches return the NOP encoding.
   assign if_ins      = (valid_q && !err_q) ? mem_rdata : 32'h0;
   assign load_count  = count_q;
   assign ld_overflow = ovf_q;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Randomized self-checking bench for imem_access_ctrl with a behavioural program/fetch model.
module tb_imem_access_ctrl;

   localparam logic [31:0] Base = 32'h0000_3000;

   logic        clock = 1'b0;
   logic        reset;
   logic        ld_valid, ld_last, ld_ready;
   logic [31:0] ld_data;
   logic        reload_req, if_req, if_gnt, if_valid, if_err;
   logic [31:0] if_addr, if_ins;
   logic [9:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata, mem_rdata;
   logic        cpu_run, ld_overflow;
   logic [10:0] load_count;

   always #5 clock = ~clock;

   imem_access_ctrl dut (
      .clock(clock), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_last(ld_last), .ld_ready(ld_ready), .reload_req(reload_req), .if_req(if_req),
      .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_ins(if_ins),
      .if_err(if_err), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .cpu_run(cpu_run), .load_count(load_count),
      .ld_overflow(ld_overflow)
   );

   // Instruction memory: synchronous write, registered read.
   logic [31:0] mem [1024];
   always @(posedge clock) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   int writes = 0;
   always @(posedge clock) if (mem_we) writes <= writes + 1;

   int          vectors = 0;
   int          miscompares = 0;
   // Reference model state
   logic [31:0] model_mem [1024];
   int          exp_cnt = 0;
   logic        exp_ovf = 1'b0;
   logic        run_m = 1'b0;
   logic        pend_v = 1'b0, pend_err = 1'b0;
   logic [31:0] pend_ins = '0;

   // Caller is at posedge+1; leaves at posedge+1 after the handshake edge.
   task automatic load_word(input logic [31:0] d, input logic last);
      ld_valid = 1'b1; ld_data = d; ld_last = last; if_req = 1'($urandom_range(0, 1));
      if_addr = Base;
      @(negedge clock);
      vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL ld_ready got %0b want 1", ld_ready); end
      vectors++; if (if_gnt !== 1'b0) begin miscompares++; $display("FAIL load_gnt got %0b want 0", if_gnt); end
      vectors++; if (cpu_run !== 1'b0) begin miscompares++; $display("FAIL load_run got %0b want 0", cpu_run); end
      vectors++; if (load_count !== 11'(exp_cnt)) begin miscompares++; $display("FAIL load_count got %0d want %0d", load_count, exp_cnt); end
      vectors++; if (ld_overflow !== exp_ovf) begin miscompares++; $display("FAIL ld_overflow got %0b want %0b", ld_overflow, exp_ovf); end
      if (exp_cnt < 1024) begin
         vectors++; if (mem_we !== 1'b1 || mem_addr !== 10'(exp_cnt) || mem_wdata !== d) begin
            miscompares++;
            $display("FAIL load_write we=%0b addr=%0d data=%h want we=1 addr=%0d data=%h", mem_we, mem_addr, mem_wdata, exp_cnt, d);
         end
         model_mem[exp_cnt] = d;
         exp_cnt++;
      end else begin
         vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL overflow_we got %0b want 0", mem_we); end
         exp_ovf = 1'b1;
      end
      @(posedge clock); #1;
      ld_valid = 1'b0; ld_last = 1'b0; if_req = 1'b0;
      if (last) run_m = 1'b1;
   endtask

   // One fetch-side cycle: checks the previous grant's result, then this cycle's grant.
   task automatic fetch_cycle(input logic [31:0] addr, input logic req, input logic reload);
      logic [31:0] off;
      logic        gnt_e, bad_e;
      if_req = req; if_addr = addr; reload_req = reload;
      off   = addr - Base;
      gnt_e = run_m && req;
      bad_e = (addr[1:0] != 2'b00) || (off >= 32'd4096);
      @(negedge clock);
      vectors++; if (cpu_run !== run_m) begin miscompares++; $display("FAIL cpu_run got %0b want %0b", cpu_run, run_m); end
      vectors++; if (if_gnt !== gnt_e) begin miscompares++; $display("FAIL if_gnt got %0b want %0b", if_gnt, gnt_e); end
      vectors++; if (if_valid !== pend_v) begin miscompares++; $display("FAIL if_valid got %0b want %0b", if_valid, pend_v); end
      if (pend_v) begin
         vectors++; if (if_err !== pend_err || if_ins !== pend_ins) begin
            miscompares++;
            $display("FAIL fetch_result err=%0b ins=%h want err=%0b ins=%h", if_err, if_ins, pend_err, pend_ins);
         end
      end
      if (run_m) begin
         vectors++; if (mem_we !== 1'b0 || ld_ready !== 1'b0) begin miscompares++; $display("FAIL run_port we=%0b ready=%0b want 0 0", mem_we, ld_ready); end
      end
      if (gnt_e) begin
         vectors++; if (mem_addr !== off[11:2]) begin miscompares++; $display("FAIL fetch_addr got %0d want %0d", mem_addr, off[11:2]); end
      end
      pend_v   = gnt_e;
      pend_err = bad_e;
      pend_ins = bad_e ? 32'h0 : model_mem[off[11:2]];
      @(posedge clock); #1;
      if (run_m && reload) run_m = 1'b0;
      if_req = 1'b0; reload_req = 1'b0;
   endtask

   task automatic do_reload(input logic [31:0] addr, input logic req);
      fetch_cycle(addr, req, 1'b1);
      fetch_cycle(Base, 1'b1, 1'b0);  // drain: request ignored, last result still delivered
      exp_cnt = 0; exp_ovf = 1'b0;
      @(negedge clock);
      vectors++; if (load_count !== 11'd0 || ld_overflow !== 1'b0) begin miscompares++; $display("FAIL reload_clear cnt=%0d ovf=%0b want 0 0", load_count, ld_overflow); end
      vectors++; if (cpu_run !== 1'b0 || ld_ready !== 1'b1 || if_valid !== 1'b0) begin
         miscompares++; $display("FAIL reload_load run=%0b ready=%0b valid=%0b want 0 1 0", cpu_run, ld_ready, if_valid);
      end
      @(posedge clock); #1;
   endtask

   task automatic fetch_random(input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = Base + 32'(4 * $urandom_range(exp_cnt - 1, 0));
         case ($urandom_range(0, 3))
            0: ;
            1: a = a + 32'($urandom_range(1, 3));
            2: a = Base + 32'd4096 + 32'(4 * $urandom_range(0, 300));
            default: a = Base - 32'(4 * $urandom_range(1, 64));
         endcase
         fetch_cycle(a, $urandom_range(0, 3) != 0, 1'b0);
      end
      fetch_cycle(Base, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
      reload_req = 1'b0; if_req = 1'b1; if_addr = Base;
      repeat (2) @(posedge clock);
      @(negedge clock);
      vectors++; if (cpu_run !== 1'b0 || if_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'd0) begin
         miscompares++; $display("FAIL reset_port run=%0b gnt=%0b we=%0b addr=%0d want 0", cpu_run, if_gnt, mem_we, mem_addr);
      end
      vectors++; if (if_valid !== 1'b0 || if_err !== 1'b0 || if_ins !== 32'h0) begin
         miscompares++; $display("FAIL reset_fetch valid=%0b err=%0b ins=%h want 0", if_valid, if_err, if_ins);
      end
      vectors++; if (load_count !== 11'd0 || ld_overflow !== 1'b0) begin
         miscompares++; $display("FAIL reset_load cnt=%0d ovf=%0b want 0 0", load_count, ld_overflow);
      end
      @(posedge clock); #1;
      reset = 1'b0; if_req = 1'b0;
      @(negedge clock);
      vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %0b want 1", ld_ready); end
      @(posedge clock); #1;
   endtask

   task automatic test_boot_load();
      load_word(32'h3C01_0001, 1'b0);
      load_word(32'h3421_0002, 1'b0);
      load_word(32'h0000_0000, 1'b1);
      @(negedge clock);
      vectors++; if (load_count !== 11'd3 || cpu_run !== 1'b1) begin
         miscompares++; $display("FAIL boot_done cnt=%0d run=%0b want 3 1", load_count, cpu_run);
      end
      @(posedge clock); #1;
   endtask

   task automatic test_back_to_back();
      fetch_cycle(32'h3000, 1'b1, 1'b0);
      fetch_cycle(32'h3004, 1'b1, 1'b0);
      fetch_cycle(32'h3008, 1'b1, 1'b0);
      fetch_cycle(32'h3000, 1'b0, 1'b0);
      fetch_cycle(32'h3000, 1'b0, 1'b0);
   endtask

   task automatic test_bad_fetch();
      fetch_cycle(32'h3002, 1'b1, 1'b0);
      fetch_cycle(32'h4000, 1'b1, 1'b0);
      fetch_cycle(32'h3000, 1'b1, 1'b0);
      fetch_cycle(32'h3000, 1'b0, 1'b0);
   endtask

   task automatic test_reload();
      do_reload(32'h3004, 1'b1);
      load_word($urandom, 1'b1);
      fetch_cycle(32'h3000, 1'b1, 1'b0);
      fetch_cycle(32'h3000, 1'b0, 1'b0);
   endtask

   task automatic test_random_program();
      int n;
      do_reload(Base, 1'b0);
      n = $urandom_range(4, 20);
      for (int i = 0; i < n; i++) load_word($urandom, i == n - 1);
      fetch_random(60);
   endtask

   task automatic test_overflow();
      int w0;
      do_reload(Base, 1'b0);
      w0 = writes;
      for (int i = 0; i < 1025; i++) load_word($urandom, i == 1024);
      @(negedge clock);
      vectors++; if (ld_overflow !== 1'b1 || load_count !== 11'd1024) begin
         miscompares++; $display("FAIL overflow_state ovf=%0b cnt=%0d want 1 1024", ld_overflow, load_count);
      end
      vectors++; if (writes - w0 !== 1024) begin miscompares++; $display("FAIL overflow_writes got %0d want 1024", writes - w0); end
      @(posedge clock); #1;
      fetch_random(40);
   endtask

   task automatic test_reset_midload();
      do_reload(Base, 1'b0);
      for (int i = 0; i < 5; i++) load_word($urandom, 1'b0);
      ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; reset = 1'b1;
      #1;
      vectors++; if (load_count !== 11'd0 || mem_we !== 1'b0 || mem_addr !== 10'd0 || cpu_run !== 1'b0) begin
         miscompares++; $display("FAIL midload_reset cnt=%0d we=%0b addr=%0d run=%0b want 0", load_count, mem_we, mem_addr, cpu_run);
      end
      @(posedge clock); #1;
      reset = 1'b0; ld_valid = 1'b0;
      exp_cnt = 0; exp_ovf = 1'b0; run_m = 1'b0; pend_v = 1'b0;
      for (int i = 0; i < 6; i++) load_word($urandom, i == 5);
      fetch_random(30);
   endtask

   initial begin
      test_reset();
      test_boot_load();
      test_back_to_back();
      test_bad_fetch();
      test_reload();
      test_random_program();
      test_overflow();
      test_reset_midload();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
